iomem_ram_ctrl: RTL and testbench
=================================

IOMEM_RAM_CTRL -- requirements
Module: iomem_ram_ctrl

Interface
REQ-001 Parameter RAM_BASE_ADDR, default 32'h4000_0000, byte base address of the RAM region.
REQ-002 Parameter RAM_MASK_ADDR, default 32'h000F_FFFF, offset mask; an address hits when (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR.
REQ-003 Parameter RAM_DEPTH, default 131072, number of 32-bit words; AW = clog2(RAM_DEPTH).
REQ-004 Parameter RAM_DELAY, default 16, legal range 3..255, cycles from request acceptance to ready.
REQ-005 Port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 Port iomem_valid_i, input, 1, bus request valid.
REQ-008 Port iomem_addr_i, input, 32, byte address.
REQ-009 Port iomem_wstrb_i, input, 4, byte write enables; all-zero means read.
REQ-010 Port iomem_wdata_i, input, 32, write data.
REQ-011 Port iomem_ready_o, output, 1, one-cycle completion pulse.
REQ-012 Port iomem_rdata_o, output, 32, registered read data.
REQ-013 Port ram_hit_o, output, 1, combinational region-hit decode of iomem_valid_i and iomem_addr_i, used for upstream ready/rdata muxing.
REQ-014 Port ram_addr_o, output, AW, word address = iomem_addr_i[AW+1:2], captured at acceptance.
REQ-015 Port ram_wr_strb_o, output, 4, RAM byte write enables.
REQ-016 Port ram_wr_data_o, output, 32, RAM write data.
REQ-017 Port ram_rd_en_o, output, 1, RAM read enable.
REQ-018 Port ram_rd_data_i, input, 32, RAM read data; valid one cycle after ram_rd_en_o.

Function
REQ-019 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE: if iomem_valid_i and the address hits, register address, wstrb and wdata, load the counter with RAM_DELAY-2, and go to ACCESS; otherwise stay in IDLE.
REQ-021 ACCESS, one cycle: drive ram_wr_strb_o with the captured strobe for a write, or ram_rd_en_o=1 for a read; go to WAIT.
REQ-022 ram_wr_strb_o and ram_rd_en_o are zero in every state other than ACCESS; each accepted request causes exactly one RAM operation.
REQ-023 WAIT: on the first WAIT cycle of a read, capture ram_rd_data_i into iomem_rdata_o; decrement the counter; go to RESP when the counter reaches 1.
REQ-024 RESP: iomem_ready_o=1 for exactly one cycle, then go to IDLE.
REQ-025 Latency: a request sampled at edge N produces iomem_ready_o high in the cycle following edge N+RAM_DELAY-1, i.e. RAM_DELAY cycles after acceptance.
REQ-026 iomem_rdata_o holds its value from capture until the next read capture; writes do not modify it.
REQ-027 Abort: if iomem_valid_i is low in WAIT or RESP, return to IDLE next cycle with no ready pulse; an already-issued write is not undone.
REQ-028 Back-to-back: a valid hit present in the IDLE cycle after RESP is accepted immediately, giving a minimum spacing of RAM_DELAY+1 cycles per transfer.
REQ-029 Non-hit addresses are never accepted; iomem_ready_o stays 0 and ram_hit_o is 0.
REQ-030 Hit offsets at or beyond RAM_DEPTH words wrap modulo RAM_DEPTH; address bits [1:0] are ignored.
REQ-031 Counter width is clog2(RAM_DELAY+1) and never underflows.

Reset
REQ-032 rst_ni low asynchronously forces: state IDLE, counter 0, iomem_ready_o 0, iomem_rdata_o 0, ram_wr_strb_o 0, ram_rd_en_o 0, captured address, strobe and data 0.
REQ-033 Reset in any state aborts the transfer; the first accepted request after release behaves as from cold start.

Structure
REQ-034 The state encoding and default region constants (RAM_BASE_ADDR, RAM_MASK_ADDR) belong in the shared package teknofest_pkg.
REQ-035 The design is a single module; no sub-module.

Verification
REQ-036 Write addr 32'h4000_0010, wdata 32'hDEAD_BEEF, wstrb 4'hF -> exactly one ram_wr_strb_o=4'hF with ram_addr_o=4; ready pulses RAM_DELAY cycles after acceptance.
REQ-037 Read-back of 32'h4000_0010 from a RAM model -> iomem_rdata_o=32'hDEAD_BEEF at ready; single ram_rd_en_o pulse.
REQ-038 Write wstrb 4'b0100, wdata 32'h00AB_0000, then read -> 32'hDEAB_BEEF.
REQ-039 Address 32'h3000_0000 with valid held for 40 cycles -> ram_hit_o=0, no ready, no RAM enables.
REQ-040 Valid dropped 5 cycles into WAIT, and separately rst_ni pulsed low mid-WAIT -> no ready pulse, all outputs at reset or idle values, next request completes in RAM_DELAY cycles.
REQ-041 Address 32'h4008_0004 with RAM_DEPTH=131072 -> ram_addr_o=1 (wrap).

Source files
------------

// File: rtl/teknofest_pkg.sv
// Shared definitions for the iomem RAM controller: FSM encoding and default
// RAM region decode constants.
package teknofest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } ram_state_t;

  localparam logic [31:0] RAM_BASE_ADDR_DEF = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK_ADDR_DEF = 32'h000F_FFFF;

endpackage

// File: rtl/iomem_ram_ctrl.sv
// iomem bus to single-port RAM bridge: decodes the RAM region, issues one RAM
// operation per accepted request and answers with a fixed-latency ready pulse.
module iomem_ram_ctrl
  import teknofest_pkg::*;
#(
  parameter logic [31:0] RAM_BASE_ADDR = RAM_BASE_ADDR_DEF,
  parameter logic [31:0] RAM_MASK_ADDR = RAM_MASK_ADDR_DEF,
  parameter int          RAM_DEPTH     = 131072,
  parameter int          RAM_DELAY     = 16,
  localparam int         AW            = $clog2(RAM_DEPTH),
  localparam int         CW            = $clog2(RAM_DELAY + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          iomem_valid_i,
  input  logic [31:0]   iomem_addr_i,
  input  logic [3:0]    iomem_wstrb_i,
  input  logic [31:0]   iomem_wdata_i,
  output logic          iomem_ready_o,
  output logic [31:0]   iomem_rdata_o,
  output logic          ram_hit_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    ram_wr_strb_o,
  output logic [31:0]   ram_wr_data_o,
  output logic          ram_rd_en_o,
  input  logic [31:0]   ram_rd_data_i
);

  // Counter starts at RAM_DELAY-2 so ACCESS + WAIT span RAM_DELAY-1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_DELAY - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ram_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] addr_reg;
  logic [3:0]    strb_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rdata_reg;
  logic          first_wait_reg;
  logic          hit;
  logic          is_read;

  assign hit       = iomem_valid_i && ((iomem_addr_i & ~RAM_MASK_ADDR) == RAM_BASE_ADDR);
  assign ram_hit_o = hit;
  assign is_read   = (strb_reg == 4'h0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (hit) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!iomem_valid_i)       state_next = ST_IDLE;
        else if (cnt_reg == CNT_ONE) state_next = ST_RESP;
      end
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Ready is gated by valid so a master that drops valid in RESP sees no pulse.
  always_comb begin
    iomem_ready_o = 1'b0;
    ram_wr_strb_o = 4'h0;
    ram_rd_en_o   = 1'b0;
    case (state_reg)
      ST_ACCESS: begin
        ram_wr_strb_o = strb_reg;
        ram_rd_en_o   = is_read;
      end
      ST_RESP:   iomem_ready_o = iomem_valid_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg        <= '0;
      addr_reg       <= '0;
      strb_reg       <= 4'h0;
      wdata_reg      <= 32'h0;
      rdata_reg      <= 32'h0;
      first_wait_reg <= 1'b0;
    end else begin
      first_wait_reg <= (state_reg == ST_ACCESS);
      case (state_reg)
        ST_IDLE: begin
          if (hit) begin
            addr_reg  <= iomem_addr_i[AW+1:2];
            strb_reg  <= iomem_wstrb_i;
            wdata_reg <= iomem_wdata_i;
            cnt_reg   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          // RAM read data is valid exactly one cycle after the ACCESS enable.
          if (first_wait_reg && is_read) rdata_reg <= ram_rd_data_i;
          if (!iomem_valid_i)            cnt_reg <= '0;
          else if (cnt_reg != '0)        cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign iomem_rdata_o = rdata_reg;
  assign ram_addr_o    = addr_reg;
  assign ram_wr_data_o = wdata_reg;

endmodule

// File: tb/tb_iomem_ram_ctrl.sv
// Directed bench for iomem_ram_ctrl with a behavioural RAM, a reference memory
// and a scoreboard queue of expected responses.
module tb_iomem_ram_ctrl;

  localparam int RAM_DELAY = 16;
  localparam int RAM_DEPTH = 131072;
  localparam int AW        = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [3:0]    wstrb = 4'h0;
  logic [31:0]   wdata = 32'h0;
  logic          ready;
  logic [31:0]   rdata;
  logic          ram_hit;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wr_strb;
  logic [31:0]   ram_wr_data;
  logic          ram_rd_en;
  logic [31:0]   ram_rd_data = 32'h0;

  iomem_ram_ctrl #(
    .RAM_BASE_ADDR(32'h4000_0000),
    .RAM_MASK_ADDR(32'h000F_FFFF),
    .RAM_DEPTH    (RAM_DEPTH),
    .RAM_DELAY    (RAM_DELAY)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .iomem_valid_i(valid),
    .iomem_addr_i (addr),
    .iomem_wstrb_i(wstrb),
    .iomem_wdata_i(wdata),
    .iomem_ready_o(ready),
    .iomem_rdata_o(rdata),
    .ram_hit_o    (ram_hit),
    .ram_addr_o   (ram_addr),
    .ram_wr_strb_o(ram_wr_strb),
    .ram_wr_data_o(ram_wr_data),
    .ram_rd_en_o  (ram_rd_en),
    .ram_rd_data_i(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with registered read.
  logic [31:0] ram_mem [int];
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (ram_wr_strb != 4'h0) begin
      tmp = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ram_wr_strb[b]) tmp[8*b +: 8] = ram_wr_data[8*b +: 8];
      ram_mem[int'(ram_addr)] = tmp;
    end
    if (ram_rd_en)
      ram_rd_data <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 32'h0;
  end

  // Event monitor, sampled on the falling edge.
  int wr_ops = 0, rd_ops = 0, ready_cnt = 0, hit_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [3:0]    last_wr_strb = 4'h0;
  always @(negedge clk) begin
    if (ram_wr_strb != 4'h0) begin
      wr_ops       <= wr_ops + 1;
      last_wr_addr <= ram_addr;
      last_wr_strb <= ram_wr_strb;
    end
    if (ram_rd_en) rd_ops    <= rd_ops + 1;
    if (ready)     ready_cnt <= ready_cnt + 1;
    if (ram_hit)   hit_cnt   <= hit_cnt + 1;
  end

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  int          checks = 0;
  int          errors = 0;

  function automatic int word_key(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request; the reference memory tracks every write the DUT will issue.
  task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit push, input logic exp_hit);
    exp_t e;
    logic [31:0] cur;
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    e.is_rd = (s == 4'h0);
    e.data  = 32'h0;
    if (exp_hit) begin
      cur = ref_mem.exists(word_key(a)) ? ref_mem[word_key(a)] : 32'h0;
      if (s == 4'h0) begin
        e.data = cur;
      end else begin
        for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        ref_mem[word_key(a)] = cur;
      end
      if (push) sb.push_back(e);
    end
    #1;
    chk("hit_decode", 32'(ram_hit), 32'(exp_hit));
  endtask

  // Counts edges from the acceptance edge until ready; expects RAM_DELAY.
  task automatic wait_ready(input string tag);
    int k = 0;
    bit got = 0;
    exp_t e;
    while (k < 200 && !got) begin
      @(posedge clk); #1;
      k++;
      if (ready) got = 1;
    end
    chk({tag, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(RAM_DELAY));
    if (got) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        if (e.is_rd) chk({tag, "_rdata"}, rdata, e.data);
      end
    end
    $display("txn %-10s addr=%h wstrb=%h wdata=%h rdata=%h cycles=%0d",
             tag, addr, wstrb, wdata, rdata, k);
  endtask

  task automatic end_txn();
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(ready), 32'd0);
    valid = 1'b0;
  endtask

  task automatic full_txn(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    int w0, r0;
    w0 = wr_ops; r0 = rd_ops;
    drive(a, s, d, 1'b1, 1'b1);
    wait_ready(tag);
    end_txn();
    chk({tag, "_wr_ops"}, 32'(wr_ops - w0), (s != 4'h0) ? 32'd1 : 32'd0);
    chk({tag, "_rd_ops"}, 32'(rd_ops - r0), (s == 4'h0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int w0, r0, rc0, hc0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr_strb", 32'(ram_wr_strb), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    full_txn("wr_beef", 32'h4000_0010, 4'hF, 32'hDEAD_BEEF);
    chk("wr_beef_addr", 32'(last_wr_addr), 32'd4);
    chk("wr_beef_strb", 32'(last_wr_strb), 32'hF);
    full_txn("rd_beef", 32'h4000_0010, 4'h0, 32'h0);
    full_txn("wr_byte2", 32'h4000_0010, 4'b0100, 32'h00AB_0000);
    full_txn("rd_merge", 32'h4000_0010, 4'h0, 32'h0);

    // Out-of-region address held valid for 40 cycles.
    w0 = wr_ops; r0 = rd_ops; rc0 = ready_cnt; hc0 = hit_cnt;
    drive(32'h3000_0000, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    valid = 1'b0;
    chk("miss_ready", 32'(ready_cnt - rc0), 32'd0);
    chk("miss_hit", 32'(hit_cnt - hc0), 32'd0);
    chk("miss_ops", 32'(wr_ops - w0 + rd_ops - r0), 32'd0);
    $display("txn miss       addr=30000000 held 40 cycles");

    // Valid dropped five cycles into WAIT.
    r0 = rd_ops; rc0 = ready_cnt;
    drive(32'h4000_0010, 4'h0, 32'h0, 1'b0, 1'b1);
    repeat (2 + 5) @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_ready", 32'(ready_cnt - rc0), 32'd0);
    chk("abort_rd_ops", 32'(rd_ops - r0), 32'd1);
    chk("abort_idle_rd_en", 32'(ram_rd_en), 32'd0);
    $display("txn abort      addr=40000010 valid dropped in WAIT");
    full_txn("post_abort", 32'h4000_0010, 4'h0, 32'h0);

    // Reset pulsed mid-WAIT after the write has been issued.
    w0 = wr_ops; rc0 = ready_cnt;
    drive(32'h4000_0020, 4'hF, 32'h1111_2222, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_wr_strb", 32'(ram_wr_strb), 32'd0);
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    chk("midrst_wdata", ram_wr_data, 32'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_ready", 32'(ready_cnt - rc0), 32'd0);
    chk("midrst_wr_ops", 32'(wr_ops - w0), 32'd1);
    $display("txn reset      addr=40000020 reset in WAIT");
    full_txn("post_rst", 32'h4000_0020, 4'h0, 32'h0);

    // Offset beyond RAM_DEPTH wraps onto word 1.
    full_txn("wr_wrap", 32'h4008_0004, 4'hF, 32'h1234_5678);
    chk("wrap_addr", 32'(last_wr_addr), 32'd1);
    full_txn("rd_wrap", 32'h4000_0004, 4'h0, 32'h0);

    // Back-to-back reads with valid held high through the turnaround.
    drive(32'h4000_0010, 4'h0, 32'h0, 1'b1, 1'b1);
    wait_ready("b2b_first");
    @(posedge clk); #1;
    chk("b2b_gap_ready", 32'(ready), 32'd0);
    addr = 32'h4000_0004;
    sb.push_back('{is_rd: 1'b1, data: 32'h1234_5678});
    wait_ready("b2b_second");
    end_txn();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
